rm_lane_scheduler: RTL and testbench

RM_LANE_SCHEDULER -- requirements
Module: rm_lane_scheduler

---
 rtl/rm_lane_scheduler_pkg.sv | 18 +
 rtl/rm_rr_picker.sv | 28 ++
 rtl/rm_lane_scheduler.sv | 148 ++++++++++++++
 tb/tb_rm_lane_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rm_lane_scheduler_pkg.sv
// Shared types and defaults for the runtime-monitor lane scheduler.
// The riscv package only carries the virtual-address width that the scheduler uses.
package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  typedef enum logic [1:0] {
    RM_FREE    = 2'd0,
    RM_ARMED   = 2'd1,
    RM_RUNNING = 2'd2,
    RM_DRAIN   = 2'd3
  } rm_lane_state_e;

  localparam int unsigned RM_NUM_LANES      = 4;
  localparam int unsigned RM_NUM_EVENTS     = 2;
  localparam int unsigned RM_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/rm_rr_picker.sv
// Round-robin picker: returns the first set bit of free_mask_i at or above ptr_i, wrapping.
module rm_rr_picker #(
  parameter int unsigned NUM_LANES = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] free_mask_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  logic [IDX_W-1:0] cand;

  // Scan offsets from far to near so the nearest free lane is the last one written.
  always_comb begin
    idx_o = ptr_i;
    cand  = ptr_i;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      cand = ptr_i + IDX_W'(k);
      if (free_mask_i[cand]) begin
        idx_o = cand;
      end
    end
  end

  assign valid_o = |free_mask_i;

endmodule

// File: rtl/rm_lane_scheduler.sv
// Allocates runtime-monitor lanes to instructions and tracks each lane through
// FREE -> ARMED -> RUNNING -> DRAIN, with flush, commit and timeout handling.
module rm_lane_scheduler
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_LANES      = RM_NUM_LANES,
  parameter int unsigned NUM_EVENTS     = RM_NUM_EVENTS,
  parameter int unsigned TIMEOUT_CYCLES = RM_TIMEOUT_CYCLES,
  localparam int unsigned IDX_W         = $clog2(NUM_LANES),
  localparam int unsigned EV_W          = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
  localparam int unsigned CNT_W         = IDX_W + 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic                                     alloc_valid_i,
  output logic                                     alloc_ready_o,
  input  logic [EV_W-1:0]                          alloc_event_i,
  input  logic [riscv::VLEN-1:0]                   alloc_pc_i,
  output logic [IDX_W-1:0]                         grant_lane_o,
  input  logic                                     commit_valid_i,
  input  logic [IDX_W-1:0]                         commit_lane_i,
  input  logic [NUM_LANES-1:0]                     lane_done_i,
  output logic [NUM_LANES-1:0]                     lane_start_o,
  output logic [NUM_LANES-1:0][EV_W-1:0]           lane_event_o,
  output logic [NUM_LANES-1:0][riscv::VLEN-1:0]    lane_pc_o,
  output logic [NUM_LANES-1:0]                     lane_busy_o,
  output logic [CNT_W-1:0]                         free_count_o,
  output logic                                     timeout_o
);

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

  logic [NUM_LANES-1:0] free_vec;
  logic [NUM_LANES-1:0] timeout_vec;
  logic [IDX_W-1:0]     ptr_reg;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 handshake;

  rm_rr_picker #(
    .NUM_LANES (NUM_LANES)
  ) u_picker (
    .free_mask_i (free_vec),
    .ptr_i       (ptr_reg),
    .idx_o       (pick_idx),
    .valid_o     (pick_valid)
  );

  // Ready depends only on registered lane state and flush, never on commit/done.
  assign alloc_ready_o = pick_valid & ~flush_i;
  assign handshake     = alloc_valid_i & alloc_ready_o;
  assign grant_lane_o  = pick_idx;
  assign timeout_o     = |timeout_vec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg <= '0;
    end else if (handshake) begin
      ptr_reg <= pick_idx + IDX_W'(1);
    end
  end

  always_comb begin
    free_count_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      free_count_o = free_count_o + CNT_W'(free_vec[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      rm_lane_state_e         state_reg, state_next;
      logic [7:0]             cnt_reg, cnt_next;
      logic                   start_reg, start_next;
      logic [EV_W-1:0]        ev_reg;
      logic [riscv::VLEN-1:0] pc_reg;
      logic                   grant_hit;
      logic                   commit_hit;
      logic                   done_hit;

      assign grant_hit  = handshake && (pick_idx == IDX_W'(gi));
      assign commit_hit = commit_valid_i && (commit_lane_i == IDX_W'(gi));
      assign done_hit   = lane_done_i[gi];

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        start_next = 1'b0;
        unique case (state_reg)
          RM_FREE: begin
            if (grant_hit) state_next = RM_ARMED;
          end
          RM_ARMED: begin
            // Commit outranks a simultaneous flush.
            if (commit_hit) begin
              state_next = RM_RUNNING;
              cnt_next   = '0;
              start_next = 1'b1;
            end else if (flush_i) begin
              state_next = RM_FREE;
            end
          end
          RM_RUNNING: begin
            if (done_hit) begin
              state_next = RM_DRAIN;
            end else if (cnt_reg == TIMEOUT_VAL) begin
              state_next = RM_FREE;
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end
          RM_DRAIN: begin
            state_next = RM_FREE;
          end
          default: state_next = RM_FREE;
        endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_reg <= RM_FREE;
          cnt_reg   <= '0;
          start_reg <= 1'b0;
          ev_reg    <= '0;
          pc_reg    <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          start_reg <= start_next;
          if (grant_hit) begin
            ev_reg <= alloc_event_i;
            pc_reg <= alloc_pc_i;
          end
        end
      end

      assign free_vec[gi]     = (state_reg == RM_FREE);
      assign lane_busy_o[gi]  = (state_reg != RM_FREE);
      assign lane_start_o[gi] = start_reg;
      assign lane_event_o[gi] = ev_reg;
      assign lane_pc_o[gi]    = pc_reg;
      assign timeout_vec[gi]  = (state_reg == RM_RUNNING) && !done_hit && (cnt_reg == TIMEOUT_VAL);
    end
  endgenerate

endmodule

// File: tb/tb_rm_lane_scheduler.sv
// Directed bench for rm_lane_scheduler: allocation order, flush/commit priority,
// timeout versus done, pointer wrap and mid-operation reset.
module tb_rm_lane_scheduler;

  localparam int unsigned NL   = 4;
  localparam int unsigned IDXW = 2;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        flush_i;
  logic                        alloc_valid_i;
  logic                        alloc_ready_o;
  logic [0:0]                  alloc_event_i;
  logic [riscv::VLEN-1:0]      alloc_pc_i;
  logic [IDXW-1:0]             grant_lane_o;
  logic                        commit_valid_i;
  logic [IDXW-1:0]             commit_lane_i;
  logic [NL-1:0]               lane_done_i;
  logic [NL-1:0]               lane_start_o;
  logic [NL-1:0][0:0]          lane_event_o;
  logic [NL-1:0][riscv::VLEN-1:0] lane_pc_o;
  logic [NL-1:0]               lane_busy_o;
  logic [IDXW:0]               free_count_o;
  logic                        timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  rm_lane_scheduler #(
    .NUM_LANES      (NL),
    .NUM_EVENTS     (2),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_event_i  (alloc_event_i),
    .alloc_pc_i     (alloc_pc_i),
    .grant_lane_o   (grant_lane_o),
    .commit_valid_i (commit_valid_i),
    .commit_lane_i  (commit_lane_i),
    .lane_done_i    (lane_done_i),
    .lane_start_o   (lane_start_o),
    .lane_event_o   (lane_event_o),
    .lane_pc_o      (lane_pc_o),
    .lane_busy_o    (lane_busy_o),
    .free_count_o   (free_count_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got %0h ok", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One-cycle allocation request; checks the combinational grant before the edge.
  task automatic alloc(input int exp_grant);
    alloc_valid_i = 1'b1;
    alloc_event_i = 1'(exp_grant);
    alloc_pc_i    = 64'h8000_0000 + 64'(exp_grant * 4);
    #1;
    chk($sformatf("grant_exp%0d", exp_grant), 64'(grant_lane_o), 64'(exp_grant));
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic commit(input int lane);
    commit_valid_i = 1'b1;
    commit_lane_i  = IDXW'(lane);
    tick();
    commit_valid_i = 1'b0;
  endtask

  task automatic flush1();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  initial begin
    int t;
    int seen;
    int pulses;

    rst_ni = 1'b0;
    flush_i = 1'b0;
    alloc_valid_i = 1'b0;
    alloc_event_i = '0;
    alloc_pc_i = '0;
    commit_valid_i = 1'b0;
    commit_lane_i = '0;
    lane_done_i = '0;

    #2;
    chk("rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_free_count", 64'(free_count_o), 64'd4);
    chk("rst_busy", 64'(lane_busy_o), 64'd0);
    chk("rst_grant", 64'(grant_lane_o), 64'd0);
    chk("rst_start", 64'(lane_start_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    tick();
    rst_ni = 1'b1;

    // Four back-to-back allocations, then a held request with no free lane.
    for (int k = 0; k < 4; k++) alloc(k);
    alloc_valid_i = 1'b1;
    #1;
    chk("full_ready", 64'(alloc_ready_o), 64'd0);
    chk("full_free_count", 64'(free_count_o), 64'd0);
    tick();
    alloc_valid_i = 1'b0;
    chk("held_busy", 64'(lane_busy_o), 64'hF);
    chk("pc_lane2", lane_pc_o[2], 64'h8000_0008);
    chk("event_lane3", 64'(lane_event_o[3]), 64'd1);
    chk("event_lane2", 64'(lane_event_o[2]), 64'd0);

    // Commit lane 2 in the same cycle as a flush.
    commit_valid_i = 1'b1;
    commit_lane_i  = 2'd2;
    flush_i        = 1'b1;
    #1;
    chk("flush_ready", 64'(alloc_ready_o), 64'd0);
    tick();
    commit_valid_i = 1'b0;
    flush_i        = 1'b0;
    chk("cf_start", 64'(lane_start_o), 64'h4);
    chk("cf_busy", 64'(lane_busy_o), 64'h4);
    chk("cf_free_count", 64'(free_count_o), 64'd3);
    tick();
    chk("cf_start_pulse_end", 64'(lane_start_o), 64'h0);

    // Commit to a RUNNING lane and done to a FREE lane are both ignored.
    commit_valid_i = 1'b1;
    commit_lane_i  = 2'd2;
    lane_done_i    = 4'b0010;
    tick();
    commit_valid_i = 1'b0;
    lane_done_i    = '0;
    chk("ign_busy", 64'(lane_busy_o), 64'h4);
    chk("ign_start", 64'(lane_start_o), 64'h0);

    // Done on lane 2: one DRAIN cycle, then FREE.
    lane_done_i = 4'b0100;
    tick();
    lane_done_i = '0;
    chk("drain_busy", 64'(lane_busy_o), 64'h4);
    tick();
    chk("drain_free", 64'(lane_busy_o), 64'h0);

    // Lane 1 runs without done until it times out.
    alloc(0);
    alloc(1);
    commit(1);
    flush_i = 1'b1;
    t = 0;
    seen = -1;
    while (t < 300) begin
      #1;
      if (timeout_o === 1'b1) begin
        seen = t;
        break;
      end
      tick();
      flush_i = 1'b0;
      t++;
    end
    flush_i = 1'b0;
    chk("timeout_cycle", 64'(seen), 64'd255);
    chk("timeout_busy_during", 64'(lane_busy_o), 64'h2);
    tick();
    chk("timeout_lane_free", 64'(lane_busy_o), 64'h0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (timeout_o === 1'b1) pulses++;
      tick();
    end
    chk("timeout_single_pulse", 64'(pulses), 64'd0);

    // Lane 0 receives done exactly at the timeout count.
    alloc(2);
    alloc(3);
    alloc(0);
    commit(0);
    flush_i = 1'b1;
    pulses = 0;
    for (int k = 0; k < 255; k++) begin
      #1;
      if (timeout_o === 1'b1) pulses++;
      tick();
      flush_i = 1'b0;
    end
    lane_done_i = 4'b0001;
    #1;
    chk("done_vs_to_timeout", 64'(timeout_o), 64'd0);
    chk("done_vs_to_early", 64'(pulses), 64'd0);
    tick();
    lane_done_i = '0;
    chk("done_vs_to_drain", 64'(lane_busy_o), 64'h1);
    chk("done_vs_to_no_pulse", 64'(timeout_o), 64'd0);
    tick();
    chk("done_vs_to_free", 64'(lane_busy_o), 64'h0);

    // Pointer at 3 with lanes 3 and 0 busy: grant wraps to 1, pointer moves to 2.
    alloc(1);
    alloc(2);
    alloc(3);
    alloc(0);
    commit(3);
    commit(0);
    flush1();
    chk("wrap_setup_busy", 64'(lane_busy_o), 64'h9);
    alloc(1);
    alloc(2);
    flush1();
    alloc(1);
    alloc(2);
    chk("wrap_busy", 64'(lane_busy_o), 64'hF);

    // Reset mid-cycle with lanes RUNNING and a commit pending.
    commit_valid_i = 1'b1;
    commit_lane_i  = 2'd1;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mrst_busy", 64'(lane_busy_o), 64'h0);
    chk("mrst_free_count", 64'(free_count_o), 64'd4);
    chk("mrst_ready", 64'(alloc_ready_o), 64'd1);
    chk("mrst_grant", 64'(grant_lane_o), 64'd0);
    chk("mrst_pc", lane_pc_o[1], 64'd0);
    chk("mrst_timeout", 64'(timeout_o), 64'd0);
    tick();
    commit_valid_i = 1'b0;
    chk("mrst_start", 64'(lane_start_o), 64'h0);
    chk("mrst_busy_held", 64'(lane_busy_o), 64'h0);
    rst_ni = 1'b1;
    alloc(0);
    chk("post_rst_busy", 64'(lane_busy_o), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
